// File: rtl/oled_spi_driver.sv
`default_nettype none
// oled_spi_driver: SSD1306 128x64 power-up, init command stream and continuous
// frame-buffer streaming over write-only 4-wire SPI (mode 0, MSB first).
module oled_spi_driver #(
    parameter int CLK_DIV       = 2,
    parameter int RESET_CYCLES  = 1000,
    parameter int FETCH_LATENCY = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic [9:0] o_pixelAddress,
    input  logic [7:0] i_pixelData,
    output logic       o_sclk,
    output logic       o_sdin,
    output logic       o_cs,
    output logic       o_dc,
    output logic       o_res,
    output logic       o_frameDone
);
    // One counter times the reset phases, the fetch wait, SCLK half-periods and the gap.
    localparam int               CNT_W      = $clog2(RESET_CYCLES + CLK_DIV + FETCH_LATENCY + 1);
    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(FETCH_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [4:0]       LAST_CMD   = 5'd24;

    typedef enum logic [2:0] {
        RST_HOLD = 3'd0,
        RST_WAIT = 3'd1,
        INIT     = 3'd2,
        FETCH    = 3'd3,
        SEND     = 3'd4,
        GAP      = 3'd5
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             phase, phase_nxt;
    logic [2:0]       bit_cnt, bit_cnt_nxt;
    logic [4:0]       cmd_idx, cmd_idx_nxt;
    logic [9:0]       byte_idx, byte_idx_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic [9:0]       addr_nxt;
    logic             sclk_nxt;
    logic             dc_nxt;
    logic             frame_done_nxt;

    function automatic logic [7:0] init_rom(input logic [4:0] idx);
        case (idx)
            5'd0:    init_rom = 8'hAE;
            5'd1:    init_rom = 8'hD5;
            5'd2:    init_rom = 8'h80;
            5'd3:    init_rom = 8'hA8;
            5'd4:    init_rom = 8'h3F;
            5'd5:    init_rom = 8'hD3;
            5'd6:    init_rom = 8'h00;
            5'd7:    init_rom = 8'h40;
            5'd8:    init_rom = 8'h8D;
            5'd9:    init_rom = 8'h14;
            5'd10:   init_rom = 8'h20;
            5'd11:   init_rom = 8'h00;
            5'd12:   init_rom = 8'hA1;
            5'd13:   init_rom = 8'hC8;
            5'd14:   init_rom = 8'hDA;
            5'd15:   init_rom = 8'h12;
            5'd16:   init_rom = 8'h81;
            5'd17:   init_rom = 8'hCF;
            5'd18:   init_rom = 8'hD9;
            5'd19:   init_rom = 8'hF1;
            5'd20:   init_rom = 8'hDB;
            5'd21:   init_rom = 8'h40;
            5'd22:   init_rom = 8'hA4;
            5'd23:   init_rom = 8'hA6;
            5'd24:   init_rom = 8'hAF;
            default: init_rom = 8'h00;
        endcase
    endfunction

    assign o_sdin = shreg[7];

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        phase_nxt      = phase;
        bit_cnt_nxt    = bit_cnt;
        cmd_idx_nxt    = cmd_idx;
        byte_idx_nxt   = byte_idx;
        shreg_nxt      = shreg;
        addr_nxt       = o_pixelAddress;
        dc_nxt         = o_dc;
        sclk_nxt       = 1'b0;
        frame_done_nxt = 1'b0;
        case (state)
            RST_HOLD, RST_WAIT: begin
                if (cnt == RST_LAST) begin
                    cnt_nxt     = '0;
                    cmd_idx_nxt = '0;
                    state_nxt   = (state == RST_HOLD) ? RST_WAIT : INIT;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            INIT: begin
                shreg_nxt   = init_rom(cmd_idx);
                dc_nxt      = 1'b0;
                cnt_nxt     = '0;
                phase_nxt   = 1'b0;
                bit_cnt_nxt = '0;
                state_nxt   = SEND;
            end
            // The address was loaded on entry, so the capture clock lands FETCH_LATENCY clocks later.
            FETCH: begin
                if (cnt == FETCH_LAST) begin
                    shreg_nxt   = i_pixelData;
                    dc_nxt      = 1'b1;
                    cnt_nxt     = '0;
                    phase_nxt   = 1'b0;
                    bit_cnt_nxt = '0;
                    state_nxt   = SEND;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            SEND: begin
                sclk_nxt = phase;
                if (cnt == DIV_LAST) begin
                    cnt_nxt   = '0;
                    phase_nxt = ~phase;
                    sclk_nxt  = ~phase;
                    if (phase) begin
                        shreg_nxt   = {shreg[6:0], 1'b0};
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_nxt      = GAP;
                            frame_done_nxt = o_dc && (byte_idx == 10'h3FF);
                        end
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            GAP: begin
                if (cnt == DIV_LAST) begin
                    cnt_nxt = '0;
                    if (!o_dc) begin
                        if (cmd_idx == LAST_CMD) begin
                            byte_idx_nxt = '0;
                            addr_nxt     = '0;
                            state_nxt    = FETCH;
                        end else begin
                            cmd_idx_nxt = cmd_idx + 5'd1;
                            state_nxt   = INIT;
                        end
                    end else begin
                        byte_idx_nxt = byte_idx + 10'd1;
                        addr_nxt     = byte_idx + 10'd1;
                        state_nxt    = FETCH;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: state_nxt = RST_HOLD;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= RST_HOLD;
            cnt            <= '0;
            phase          <= 1'b0;
            bit_cnt        <= '0;
            cmd_idx        <= '0;
            byte_idx       <= '0;
            shreg          <= '0;
            o_pixelAddress <= '0;
            o_sclk         <= 1'b0;
            o_cs           <= 1'b1;
            o_dc           <= 1'b0;
            o_res          <= 1'b0;
            o_frameDone    <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            phase          <= phase_nxt;
            bit_cnt        <= bit_cnt_nxt;
            cmd_idx        <= cmd_idx_nxt;
            byte_idx       <= byte_idx_nxt;
            shreg          <= shreg_nxt;
            o_pixelAddress <= addr_nxt;
            o_sclk         <= sclk_nxt;
            o_cs           <= (state_nxt != SEND);
            o_dc           <= dc_nxt;
            o_res          <= (state_nxt != RST_HOLD);
            o_frameDone    <= frame_done_nxt;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_oled_spi_driver.sv
`default_nettype none
// tb_oled_spi_driver: three driver instances (fetch latency matched, longer, and mismatched)
// are sniffed on SPI and compared against a byte-stream model of the panel traffic.
module tb_oled_spi_driver;
    localparam int CD     = 2;
    localparam int RC     = 10;
    localparam int N_INIT = 25;
    localparam int FL_OF  [3] = '{2, 3, 2};
    localparam int LAT_OF [3] = '{2, 3, 3};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] addr  [3];
    logic [7:0] pdata [3];
    logic       sclk  [3];
    logic       sdin  [3];
    logic       cs    [3];
    logic       dc    [3];
    logic       res   [3];
    logic       fd    [3];

    oled_spi_driver #(.CLK_DIV(CD), .RESET_CYCLES(RC), .FETCH_LATENCY(2)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .o_pixelAddress(addr[0]), .i_pixelData(pdata[0]),
        .o_sclk(sclk[0]), .o_sdin(sdin[0]), .o_cs(cs[0]), .o_dc(dc[0]), .o_res(res[0]),
        .o_frameDone(fd[0]));
    oled_spi_driver #(.CLK_DIV(CD), .RESET_CYCLES(RC), .FETCH_LATENCY(3)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .o_pixelAddress(addr[1]), .i_pixelData(pdata[1]),
        .o_sclk(sclk[1]), .o_sdin(sdin[1]), .o_cs(cs[1]), .o_dc(dc[1]), .o_res(res[1]),
        .o_frameDone(fd[1]));
    oled_spi_driver #(.CLK_DIV(CD), .RESET_CYCLES(RC), .FETCH_LATENCY(2)) u_dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .o_pixelAddress(addr[2]), .i_pixelData(pdata[2]),
        .o_sclk(sclk[2]), .o_sdin(sdin[2]), .o_cs(cs[2]), .o_dc(dc[2]), .o_res(res[2]),
        .o_frameDone(fd[2]));

    // Text-engine stand-in: frame contents in mem, returned LAT_OF[d] clocks after an address change.
    logic [7:0] mem  [1024];
    logic [9:0] pipe [3][3];
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            pipe[d][0] <= addr[d];
            pipe[d][1] <= pipe[d][0];
            pipe[d][2] <= pipe[d][1];
        end
    end
    assign pdata[0] = mem[pipe[0][1]];
    assign pdata[1] = mem[pipe[1][2]];
    assign pdata[2] = mem[pipe[2][2]];

    logic [7:0] rom [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
                             8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
                             8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stream position p: 25 commands, then frame bytes forever. A driver that captures
    // one clock too early sees the byte of the previously addressed index.
    function automatic logic [8:0] exp_byte(input int d, input int p);
        int idx;
        int prv;
        if (p < N_INIT) return {1'b0, rom[p]};
        idx = (p - N_INIT) % 1024;
        if (LAT_OF[d] > FL_OF[d]) begin
            prv = (idx != 0) ? idx - 1 : ((p == N_INIT) ? 0 : 1023);
            return {1'b1, mem[prv]};
        end
        return {1'b1, mem[idx]};
    endfunction

    // SPI sniffer state per instance.
    int         t = 0;
    int         pos [3];
    int         rises [3];
    int         low_len [3];
    int         high_len [3];
    int         last_rise [3];
    int         fd_count = 0;
    logic [7:0] sh [3];
    logic       dc_cap [3];
    logic       dc_ok [3];
    logic       spacing_ok [3];
    logic       stable_ok [3];
    logic       has_prev [3];
    logic       p_cs [3];
    logic       p_sclk [3];
    logic       p_sdin [3];
    logic [9:0] p_addr [3];

    initial begin
        logic [8:0] e;
        logic       is_last;
        forever begin
            @(negedge clk);
            t++;
            for (int d = 0; d < 3; d++) begin
                if (!rst_n) begin
                    pos[d]      = 0;
                    rises[d]    = 0;
                    high_len[d] = 0;
                    has_prev[d] = 1'b0;
                    p_cs[d]     = 1'b1;
                    p_sclk[d]   = 1'b0;
                    p_sdin[d]   = 1'b0;
                    p_addr[d]   = '0;
                end else begin
                    if (addr[d] != p_addr[d])
                        check($sformatf("addr_seq%0d", d), 32'(addr[d]), 32'(10'(p_addr[d] + 10'd1)));
                    if (p_cs[d] && !cs[d]) begin
                        if (has_prev[d])
                            check($sformatf("cs_high%0d", d), high_len[d],
                                  (pos[d] < N_INIT) ? CD + 1 : CD + 1 + FL_OF[d]);
                        rises[d]      = 0;
                        low_len[d]    = 0;
                        high_len[d]   = 0;
                        sh[d]         = '0;
                        dc_cap[d]     = dc[d];
                        dc_ok[d]      = 1'b1;
                        spacing_ok[d] = 1'b1;
                        stable_ok[d]  = 1'b1;
                    end
                    if (!cs[d]) begin
                        low_len[d]++;
                        if (dc[d] != dc_cap[d]) dc_ok[d] = 1'b0;
                        if (sclk[d] && !p_sclk[d]) begin
                            rises[d]++;
                            sh[d] = {sh[d][6:0], sdin[d]};
                            if (rises[d] > 1 && (t - last_rise[d]) != 2 * CD) spacing_ok[d] = 1'b0;
                            last_rise[d] = t;
                        end
                        if (sclk[d] && (sdin[d] != p_sdin[d])) stable_ok[d] = 1'b0;
                    end else begin
                        high_len[d]++;
                    end
                    if (!p_cs[d] && cs[d]) begin
                        e       = exp_byte(d, pos[d]);
                        is_last = (pos[d] >= N_INIT) && (((pos[d] - N_INIT) % 1024) == 1023);
                        check($sformatf("byte%0d_pos%0d", d, pos[d]), 32'({dc_cap[d], sh[d]}), 32'(e));
                        check($sformatf("bit_count%0d", d), rises[d], 8);
                        check($sformatf("cs_low%0d", d), low_len[d], 16 * CD);
                        check($sformatf("sclk_spacing%0d", d), 32'(spacing_ok[d]), 32'(1));
                        check($sformatf("sdin_stable%0d", d), 32'(stable_ok[d]), 32'(1));
                        check($sformatf("dc_stable%0d", d), 32'(dc_ok[d]), 32'(1));
                        check($sformatf("sclk_idle%0d", d), 32'(sclk[d]), 32'(0));
                        check($sformatf("frame_done%0d_pos%0d", d, pos[d]), 32'(fd[d]), 32'(is_last));
                        if (d == 0 && fd[d]) fd_count++;
                        pos[d]++;
                        has_prev[d] = 1'b1;
                    end else if (fd[d]) begin
                        check($sformatf("frame_done_stray%0d", d), 32'(fd[d]), 32'(0));
                    end
                    p_cs[d]   = cs[d];
                    p_sclk[d] = sclk[d];
                    p_sdin[d] = sdin[d];
                    p_addr[d] = addr[d];
                end
            end
        end
    end

    task automatic check_reset_values(input string tag);
        for (int d = 0; d < 3; d++)
            check($sformatf("%s%0d", tag, d),
                  32'({res[d], cs[d], sclk[d], sdin[d], dc[d], addr[d], fd[d]}),
                  32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0}));
    endtask

    // Counts clocks from reset release to o_res rise, o_cs fall and first SCLK rise.
    task automatic powerup_check(input string tag);
        int n;
        n = 0;
        while (res[0] !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        check({tag, "_res_low"}, n, RC);
        while (cs[0] !== 1'b0 && n < 200) begin @(posedge clk); #1; n++; end
        check({tag, "_cs_fall"}, n, 2 * RC + 1);
        check({tag, "_init_dc"}, 32'(dc[0]), 32'(0));
        while (sclk[0] !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        check({tag, "_first_sclk"}, n, 2 * RC + 1 + CD);
    endtask

    initial begin
        int   n;
        logic reached;
        for (int k = 0; k < 1024; k++) mem[k] = 8'($urandom);
        mem[5]    = 8'h05;
        mem[1023] = 8'hFF;

        repeat (3) @(posedge clk);
        #2;
        check_reset_values("reset_hold");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        powerup_check("pwr1");

        // Run through a whole frame and into byte 200 of the next one.
        n = 0;
        reached = 1'b0;
        while (!reached && n < 60000) begin
            @(posedge clk);
            #2;
            n++;
            reached = (pos[0] == N_INIT + 1024 + 200) && (rises[0] == 3) && (cs[0] == 1'b0);
        end
        check("reach_byte200_bit3", 32'(reached), 32'(1));
        check("frame_done_pulses", fd_count, 1);

        rst_n = 1'b0;
        #1;
        check_reset_values("reset_mid");
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b1;
        powerup_check("pwr2");

        n = 0;
        while (pos[0] < N_INIT + 5 && n < 5000) begin @(posedge clk); #2; n++; end
        check("restart_progress", 32'(pos[0] >= N_INIT + 5), 32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
`default_nettype wire
